keypad_pin_lock: RTL
====================

Name: keypad_pin_lock

Overview:
- Consumes the 4-bit key code N[3:0] and key-valid strobe V from the 3x4 keypad scanner.
- Implements a PIN-entry lock: collects digits, compares against a stored PIN on '#', drives an unlock output for a fixed window and allows the PIN to be reprogrammed while unlocked.
- Enforces a lockout period after repeated failed attempts.
- Key encoding: 0-9 are digits, 10 is '*', 11 is '#', 12-15 are ignored.

Parameters:
- PIN_LEN, 4: digits per PIN; legal range 1-7.
- DEFAULT_PIN, 28'h0001234: reset PIN in BCD, first-entered digit in the most significant used nibble; only the low 4*PIN_LEN bits are used.
- MAX_TRIES, 3: consecutive failures that trigger lockout; legal range 1-7.
- UNLOCK_CYCLES, 500: CLK cycles UNLOCK stays high; also the NEWPIN timeout; legal range 1-65535.
- LOCKOUT_CYCLES, 1000: CLK cycles keys are ignored after lockout; legal range 1-65535.

Ports:
- CLK  input  1  system clock; rising-edge.
- RST_N  input  1  synchronous active-low reset.
- N  input  4  key code from scanner.
- V  input  1  key-valid from scanner.
- UNLOCK  output  1  high while in UNLOCKED.
- ERR  output  1  one-cycle pulse on a failed compare or an invalid new PIN.
- LOCKOUT  output  1  high while in LOCKOUT.
- PROG  output  1  high while in NEWPIN.
- DCNT  output  3  digits held in the entry buffer (saturates at PIN_LEN).

Behaviour:
- Reset and clocking:
  - One clock, CLK.
  - Reset is synchronous and active-low: RST_N sampled low at a CLK rising edge resets the block.
  - Reset values: state=ENTRY, buffer=0, DCNT=0, overflow=0, tries=0, timer=0, stored PIN=DEFAULT_PIN, UNLOCK=0, ERR=0, LOCKOUT=0, PROG=0.
  - Reset mid-operation aborts any state, restores DEFAULT_PIN and clears tries.
- Key accept:
  - Internal register vd <= V.
  - A key event is accepted on the cycle where V=1 and vd=0, so a V held high for several cycles counts as one key.
  - N is sampled in that same cycle.
  - All state and output updates take effect on the next CLK edge, i.e. 1-cycle latency from accepted key to output change.
- Entry buffer:
  - A digit shifts left into the buffer: buf <= {buf[4*PIN_LEN-5:0], N}.
  - DCNT increments per digit up to PIN_LEN.
  - A digit arriving with DCNT==PIN_LEN is discarded and sets overflow.
  - Clearing the buffer sets buf=0, DCNT=0, overflow=0.
- ENTRY state:
  - digit: load buffer.
  - '*': clear buffer.
  - '#': compare; match iff DCNT==PIN_LEN, overflow==0 and buf==PIN. The buffer is cleared in both cases.
  - On match: go to UNLOCKED, timer=UNLOCK_CYCLES, tries=0.
  - On mismatch: ERR=1 for one cycle, tries+1. If tries+1==MAX_TRIES, go to LOCKOUT with timer=LOCKOUT_CYCLES; else stay in ENTRY.
  - '#' with DCNT==0 counts as a mismatch.
- UNLOCKED state (UNLOCK=1):
  - Timer decrements each cycle; leaves for ENTRY on the cycle the timer reaches 0, so UNLOCK is high for exactly UNLOCK_CYCLES cycles.
  - '#' relocks immediately: go to ENTRY.
  - '*' goes to NEWPIN, buffer cleared, timer reloaded with UNLOCK_CYCLES, UNLOCK drops.
  - Digits are ignored.
- NEWPIN state (PROG=1):
  - Digits load the buffer.
  - '#' with DCNT==PIN_LEN and overflow==0: PIN<=buf, then go to ENTRY.
  - '#' otherwise: ERR pulse, PIN unchanged, go to ENTRY.
  - '*': abort to ENTRY, PIN unchanged, no ERR.
  - Timer expiry: abort to ENTRY, PIN unchanged.
  - NEWPIN outcomes do not change tries.
  - The buffer is cleared on every exit.
- LOCKOUT state (LOCKOUT=1):
  - All keys are ignored and the buffer is held cleared.
  - After LOCKOUT_CYCLES cycles, tries=0 and the state returns to ENTRY.
- Key events always take priority over timer expiry when both occur in the same cycle.
- Codes 12-15 are treated as no key in every state.
- Timer is 16 bits.
- Outputs are registered, glitch-free functions of state; ERR is a registered one-cycle pulse.

Test Plan:
- Reset, then keys 1,2,3,4,# -> DCNT steps 1..4; UNLOCK rises one cycle after '#' and stays high exactly 500 cycles; ERR stays 0.
- Keys 1,2,3,5,# three times -> ERR pulses three times; after the 3rd, LOCKOUT=1 for 1000 cycles; keys 1,2,3,4,# during lockout -> no UNLOCK; after lockout, 1,2,3,4,# -> UNLOCK=1.
- Keys 1,2,3,4,5,# (overflow) -> ERR pulse, no unlock; keys 1,2,*,1,2,3,4,# -> UNLOCK=1 ('*' cleared the partial entry).
- While unlocked, press *,9,8,7,6,# -> PROG high between '*' and '#'; then 1,2,3,4,# -> ERR; then 9,8,7,6,# -> UNLOCK=1.
- Hold V high for 10 cycles with N=5 -> DCNT increments by exactly 1; N=13 with V pulse -> no state change.
- RST_N low for one cycle during LOCKOUT and during NEWPIN -> all outputs 0, DCNT=0; keys 1,2,3,4,# -> UNLOCK=1 (DEFAULT_PIN restored).

Source files
------------

// File: rtl/keypad_pin_lock.sv
// keypad_pin_lock: PIN-entry lock fed by a 3x4 keypad scanner.
//   Collects digits into an entry buffer and compares them against the stored
//   PIN when '#' is pressed. A match opens an unlock window. While unlocked,
//   '*' starts reprogramming the PIN. Repeated failures force a lockout period.
// Ports:
//   CLK      system clock, rising edge
//   RST_N    synchronous active-low reset
//   N[3:0]   key code: 0-9 digit, 10 '*', 11 '#', 12-15 ignored
//   V        key-valid strobe; its rising edge is one key event
//   UNLOCK   high while unlocked
//   ERR      one-cycle pulse on a failed compare or an invalid new PIN
//   LOCKOUT  high while locked out
//   PROG     high while a new PIN is being entered
//   DCNT     digits held in the entry buffer, saturating at PIN_LEN
module keypad_pin_lock #(
  parameter int unsigned PIN_LEN        = 4,
  parameter logic [27:0] DEFAULT_PIN    = 28'h0001234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] N,
  input  logic       V,
  output logic       UNLOCK,
  output logic       ERR,
  output logic       LOCKOUT,
  output logic       PROG,
  output logic [2:0] DCNT
);

  localparam int unsigned BUF_W    = 4 * PIN_LEN;
  localparam int unsigned TIMER_W  = 16;
  localparam logic [2:0]  LEN_3    = 3'(PIN_LEN);
  localparam logic [2:0]  TRIES_3  = 3'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] UNLOCK_T = TIMER_W'(UNLOCK_CYCLES);
  localparam logic [TIMER_W-1:0] LOCK_T   = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [BUF_W-1:0]   PIN_RST  = BUF_W'(DEFAULT_PIN);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_UNLOCKED,
    S_NEWPIN,
    S_LOCKOUT
  } state_t;

  state_t               state;
  logic                 vd;
  logic [BUF_W-1:0]     entry_buf;
  logic [BUF_W-1:0]     pin;
  logic                 ovf;
  logic [2:0]           tries;
  logic [TIMER_W-1:0]   timer;

  logic                 key_ev;
  logic                 is_digit;
  logic                 is_star;
  logic                 is_hash;
  logic                 buf_full;
  logic                 pin_ok;
  logic                 expire;
  logic [2:0]           tries_inc;
  logic [BUF_W-1:0]     buf_shift;
  logic [TIMER_W-1:0]   timer_dec;

  // Key decode: one event per rising edge of V; codes 12-15 decode to nothing.
  always_comb begin
    key_ev    = V & ~vd;
    is_digit  = key_ev & (N <= 4'd9);
    is_star   = key_ev & (N == 4'd10);
    is_hash   = key_ev & (N == 4'd11);
    buf_full  = (DCNT == LEN_3);
    pin_ok    = buf_full & ~ovf & (entry_buf == pin);
    tries_inc = tries + 3'd1;
    // Truncating cast drops the oldest nibble; also covers PIN_LEN == 1.
    buf_shift = BUF_W'({entry_buf, N});
    // A timer at 1 expires this edge. A timer held at 0 also counts as
    // expired, so a key that took priority on the last cycle lets expiry follow.
    expire    = (timer <= TIMER_W'(1));
    timer_dec = (timer == '0) ? '0 : timer - TIMER_W'(1);
  end

  // Lock FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_ENTRY;
      vd        <= 1'b0;
      entry_buf <= '0;
      pin       <= PIN_RST;
      ovf       <= 1'b0;
      tries     <= '0;
      timer     <= '0;
      UNLOCK    <= 1'b0;
      ERR       <= 1'b0;
      LOCKOUT   <= 1'b0;
      PROG      <= 1'b0;
      DCNT      <= '0;
    end else begin
      vd  <= V;
      ERR <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (is_digit) begin
            if (buf_full) begin
              ovf <= 1'b1;
            end else begin
              entry_buf <= buf_shift;
              DCNT      <= DCNT + 3'd1;
            end
          end else if (is_star) begin
            entry_buf <= '0;
            DCNT      <= '0;
            ovf       <= 1'b0;
          end else if (is_hash) begin
            entry_buf <= '0;
            DCNT      <= '0;
            ovf       <= 1'b0;
            if (pin_ok) begin
              state  <= S_UNLOCKED;
              UNLOCK <= 1'b1;
              timer  <= UNLOCK_T;
              tries  <= '0;
            end else begin
              ERR   <= 1'b1;
              tries <= tries_inc;
              if (tries_inc == TRIES_3) begin
                state   <= S_LOCKOUT;
                LOCKOUT <= 1'b1;
                timer   <= LOCK_T;
              end
            end
          end
        end

        // Digits are ignored here, so only '#', '*' or expiry leave.
        S_UNLOCKED: begin
          if (is_hash) begin
            state  <= S_ENTRY;
            UNLOCK <= 1'b0;
            timer  <= '0;
          end else if (is_star) begin
            state     <= S_NEWPIN;
            UNLOCK    <= 1'b0;
            PROG      <= 1'b1;
            timer     <= UNLOCK_T;
            entry_buf <= '0;
            DCNT      <= '0;
            ovf       <= 1'b0;
          end else if (expire) begin
            state  <= S_ENTRY;
            UNLOCK <= 1'b0;
            timer  <= '0;
          end else begin
            timer <= timer_dec;
          end
        end

        // Every exit clears the buffer; tries is left untouched.
        S_NEWPIN: begin
          if (is_digit) begin
            if (buf_full) begin
              ovf <= 1'b1;
            end else begin
              entry_buf <= buf_shift;
              DCNT      <= DCNT + 3'd1;
            end
            timer <= timer_dec;
          end else if (is_star || is_hash || expire) begin
            if (is_hash) begin
              if (buf_full && !ovf) begin
                pin <= entry_buf;
              end else begin
                ERR <= 1'b1;
              end
            end
            state     <= S_ENTRY;
            PROG      <= 1'b0;
            timer     <= '0;
            entry_buf <= '0;
            DCNT      <= '0;
            ovf       <= 1'b0;
          end else begin
            timer <= timer_dec;
          end
        end

        // Keys are ignored and the buffer is held cleared.
        S_LOCKOUT: begin
          entry_buf <= '0;
          DCNT      <= '0;
          ovf       <= 1'b0;
          if (expire) begin
            state   <= S_ENTRY;
            LOCKOUT <= 1'b0;
            tries   <= '0;
            timer   <= '0;
          end else begin
            timer <= timer_dec;
          end
        end

        default: begin
          state   <= S_ENTRY;
          UNLOCK  <= 1'b0;
          LOCKOUT <= 1'b0;
          PROG    <= 1'b0;
          timer   <= '0;
        end
      endcase
    end
  end

endmodule
